// File: rtl/system_monitor_cmd_receiver.sv
// Host-to-FPGA command receiver for the system monitor UART link. Frames the RX byte
// stream as sync/header/length/payload/checksum and hands validated commands to the register logic.
module system_monitor_cmd_receiver #(
  parameter int         NUM_CH         = 8,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  localparam int        CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int        LEN_W          = $clog2(MAX_LEN + 1),
  localparam int        ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int        TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              uartDisabled,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CH_W-1:0]   cmd_channel,
  output logic [LEN_W-1:0]  cmd_length,
  input  logic [ADDR_W-1:0] cmd_rd_addr,
  output logic [7:0]        cmd_rd_data,
  output logic              frame_error,
  output logic [7:0]        error_count,
  output logic              busy
);

  localparam logic [7:0]       NUM_CH_B  = 8'(NUM_CH);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int               DEPTH     = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LENGTH,
    ST_PAYLOAD,
    ST_CHECKSUM,
    ST_DELIVER
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_W-1:0]    r_chan;
  logic [LEN_W-1:0]   r_len;
  logic [ADDR_W-1:0]  r_idx;
  logic [7:0]         r_sum;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_frame_error;
  logic [7:0]         r_err_cnt;
  logic [7:0]         r_rd_data;
  logic [7:0]         r_buf [DEPTH];

  logic               w_err;
  logic               w_ld_hdr;
  logic               w_ld_len;
  logic               w_wr_pay;
  logic               w_hdr_ok;
  logic               w_len_ok;
  logic               w_last_pay;
  logic               w_tmo_hit;
  logic               w_in_frame_nxt;
  logic [7:0]         w_sum_add;

  assign w_hdr_ok       = (rx_data[7] == 1'b0) && ({1'b0, rx_data[6:0]} < NUM_CH_B);
  assign w_len_ok       = (rx_data != 8'h00) && (rx_data <= MAX_LEN_B);
  assign w_last_pay     = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
  assign w_tmo_hit      = (r_tmo_cnt == TMO_LAST);
  assign w_sum_add      = r_sum + rx_data;
  assign w_in_frame_nxt = (w_state_nxt == ST_HEADER)  || (w_state_nxt == ST_LENGTH) ||
                          (w_state_nxt == ST_PAYLOAD) || (w_state_nxt == ST_CHECKSUM);

  // NOTE: state and all other registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_ld_hdr    = 1'b0;
    w_ld_len    = 1'b0;
    w_wr_pay    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && !uartDisabled && (rx_data == SYNC_BYTE)) w_state_nxt = ST_HEADER;
      end
      ST_HEADER, ST_LENGTH, ST_PAYLOAD, ST_CHECKSUM: begin
        // The menu owns the link while uartDisabled is high: abort quietly.
        if (uartDisabled) begin
          w_state_nxt = ST_IDLE;
        end else if (!rx_valid) begin
          if (w_tmo_hit) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          case (r_state)
            ST_HEADER: begin
              if (w_hdr_ok) begin
                w_ld_hdr    = 1'b1;
                w_state_nxt = ST_LENGTH;
              end else begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
              end
            end
            ST_LENGTH: begin
              if (w_len_ok) begin
                w_ld_len    = 1'b1;
                w_state_nxt = ST_PAYLOAD;
              end else begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
              end
            end
            ST_PAYLOAD: begin
              w_wr_pay = 1'b1;
              if (w_last_pay) w_state_nxt = ST_CHECKSUM;
            end
            default: begin
              if (w_sum_add == 8'h00) begin
                w_state_nxt = ST_DELIVER;
              end else begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
              end
            end
          endcase
        end
      end
      ST_DELIVER: begin
        // Bytes arriving while a command is pending are overruns; the command stays put.
        if (rx_valid)  w_err       = 1'b1;
        if (cmd_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chan        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_sum         <= '0;
      r_tmo_cnt     <= '0;
      r_frame_error <= 1'b0;
      r_err_cnt     <= '0;
      r_rd_data     <= '0;
    end else begin
      r_frame_error <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      if (rx_valid || !w_in_frame_nxt) r_tmo_cnt <= '0;
      else                             r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (w_ld_hdr) begin
        r_chan <= rx_data[CH_W-1:0];
        r_sum  <= rx_data;
      end
      if (w_ld_len) begin
        r_len <= rx_data[LEN_W-1:0];
        r_sum <= w_sum_add;
        r_idx <= '0;
      end
      if (w_wr_pay) begin
        r_sum <= w_sum_add;
        r_idx <= r_idx + ADDR_W'(1);
      end

      r_rd_data <= r_buf[cmd_rd_addr];
    end
  end

  // NOTE: the payload buffer has no reset; it is always written before cmd_valid exposes it.
  always_ff @(posedge clk) begin
    if (w_wr_pay) r_buf[r_idx] <= rx_data;
  end

  assign cmd_valid   = (r_state == ST_DELIVER);
  assign busy        = (r_state != ST_IDLE);
  assign cmd_channel = r_chan;
  assign cmd_length  = r_len;
  assign cmd_rd_data = r_rd_data;
  assign frame_error = r_frame_error;
  assign error_count = r_err_cnt;

endmodule

// File: tb/tb_system_monitor_cmd_receiver.sv
// Self-checking bench for system_monitor_cmd_receiver: a per-byte vector table for
// framing/error rules plus directed sequences for delivery, timeout, overrun and reset.
module tb_system_monitor_cmd_receiver;

  localparam int TMO = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       uartDisabled;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_channel;
  logic [4:0] cmd_length;
  logic [3:0] cmd_rd_addr;
  logic [7:0] cmd_rd_data;
  logic       frame_error;
  logic [7:0] error_count;
  logic       busy;

  int total = 0;
  int bad   = 0;

  system_monitor_cmd_receiver #(
    .NUM_CH(8), .MAX_LEN(16), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .uartDisabled(uartDisabled), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel), .cmd_length(cmd_length), .cmd_rd_addr(cmd_rd_addr),
    .cmd_rd_data(cmd_rd_data), .frame_error(frame_error), .error_count(error_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       busy;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte is presented for one cycle; on return we sit at the negedge after it was consumed.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] addr, input logic [7:0] exp);
    cmd_rd_addr = addr;
    @(negedge clk);
    check(name, cmd_rd_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] payload [16];
    logic [7:0] sum;
    logic [7:0] exp_cnt;
    int         seen;
    logic       busy_mid;

    vecs[0]  = '{8'h00, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{8'hA5, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{8'h03, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{8'h02, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{8'h11, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{8'h22, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{8'hC9, 1'b0, 1'b1, 8'd1};
    vecs[7]  = '{8'hA5, 1'b1, 1'b0, 8'd1};
    vecs[8]  = '{8'h09, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{8'hA5, 1'b1, 1'b0, 8'd2};
    vecs[10] = '{8'h83, 1'b0, 1'b1, 8'd3};
    vecs[11] = '{8'hA5, 1'b1, 1'b0, 8'd3};
    vecs[12] = '{8'h01, 1'b1, 1'b0, 8'd3};
    vecs[13] = '{8'h00, 1'b0, 1'b1, 8'd4};
    vecs[14] = '{8'hA5, 1'b1, 1'b0, 8'd4};
    vecs[15] = '{8'h05, 1'b1, 1'b0, 8'd4};
    vecs[16] = '{8'h11, 1'b0, 1'b1, 8'd5};
    vecs[17] = '{8'hA5, 1'b1, 1'b0, 8'd5};
    vecs[18] = '{8'hA5, 1'b0, 1'b1, 8'd6};
    vecs[19] = '{8'h3C, 1'b0, 1'b0, 8'd6};

    reset        = 1'b1;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    uartDisabled = 1'b0;
    cmd_ready    = 1'b0;
    cmd_rd_addr  = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_error, 0);
    check("rst_cnt", error_count, 0);
    check("rst_chan", cmd_channel, 0);
    check("rst_len", cmd_length, 0);
    check("rst_rd", cmd_rd_data, 0);
    reset = 1'b0;

    // Basic delivery with a stalled consumer, then handshake.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'hC8);
    check("t1_valid", cmd_valid, 1);
    check("t1_chan", cmd_channel, 3);
    check("t1_len", cmd_length, 2);
    read_check("t1_rd0", 4'd0, 8'h11);
    read_check("t1_rd1", 4'd1, 8'h22);
    repeat (3) @(negedge clk);
    check("t1_hold", cmd_valid, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("t1_released", cmd_valid, 0);
    check("t1_idle", busy, 0);
    check("t1_cnt", error_count, 0);

    // Per-byte framing and error rules.
    for (int i = 0; i < NV; i++) begin
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_err", i), frame_error, vecs[i].err);
      check($sformatf("vec%0d_cnt", i), error_count, vecs[i].cnt);
      check($sformatf("vec%0d_valid", i), cmd_valid, 0);
    end
    exp_cnt = 8'd6;

    // Maximum-length frame with a SYNC value inside the payload.
    sum = 8'h07 + 8'h10;
    for (int i = 0; i < 16; i++) begin
      payload[i] = (i == 3) ? 8'hA5 : 8'(8'h30 + i);
      sum = sum + payload[i];
    end
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(payload[i]);
    send_byte(8'h00 - sum);
    check("max_valid", cmd_valid, 1);
    check("max_chan", cmd_channel, 7);
    check("max_len", cmd_length, 16);
    for (int i = 0; i < 16; i++) read_check($sformatf("max_rd%0d", i), 4'(i), payload[i]);
    check("max_cnt", error_count, exp_cnt);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("max_released", cmd_valid, 0);

    // Inter-byte timeout.
    send_byte(8'hA5); send_byte(8'h03);
    seen = 0;
    busy_mid = 1'b0;
    for (int k = 1; k <= TMO + 4; k++) begin
      @(negedge clk);
      if (k == TMO - 2) busy_mid = busy;
      if (frame_error) begin
        seen = k;
        break;
      end
    end
    exp_cnt = exp_cnt + 8'd1;
    check("tmo_busy_before", busy_mid, 1);
    check("tmo_in_window", (seen >= TMO) && (seen <= TMO + 1), 1);
    check("tmo_idle", busy, 0);
    check("tmo_cnt", error_count, exp_cnt);

    // uartDisabled aborts a frame silently and masks SYNC in IDLE.
    send_byte(8'hA5); send_byte(8'h03);
    @(negedge clk);
    uartDisabled = 1'b1;
    @(negedge clk);
    check("dis_abort_busy", busy, 0);
    check("dis_abort_err", frame_error, 0);
    send_byte(8'hA5);
    check("dis_idle_sync", busy, 0);
    repeat (TMO + 4) @(negedge clk);
    uartDisabled = 1'b0;
    check("dis_cnt", error_count, exp_cnt);

    // Overruns while a command is pending, counter saturation, then delivery.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h5A); send_byte(8'hA3);
    check("ovr_valid", cmd_valid, 1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'h12); send_byte(8'h34);
    exp_cnt = exp_cnt + 8'd5;
    check("ovr_pulse", frame_error, 1);
    check("ovr_cnt", error_count, exp_cnt);
    check("ovr_still_valid", cmd_valid, 1);
    check("ovr_chan", cmd_channel, 2);
    check("ovr_len", cmd_length, 1);
    read_check("ovr_rd0", 4'd0, 8'h5A);
    for (int i = 0; i < 250; i++) send_byte(8'h55);
    check("sat_cnt", error_count, 8'hFF);
    check("sat_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("ovr_released", cmd_valid, 0);
    // Consumer already ready when cmd_valid rises: one-cycle transfer.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    send_byte(8'h77); send_byte(8'h84);
    check("rdy_valid", cmd_valid, 1);
    check("rdy_chan", cmd_channel, 4);
    @(negedge clk);
    check("rdy_released", cmd_valid, 0);
    cmd_ready = 1'b0;

    // Reset mid-payload, then a full frame.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", error_count, 0);
    check("mid_rst_chan", cmd_channel, 0);
    check("mid_rst_len", cmd_length, 0);
    check("mid_rst_valid", cmd_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'hA5); send_byte(8'h06); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'hF1);
    check("post_rst_valid", cmd_valid, 1);
    check("post_rst_chan", cmd_channel, 6);
    check("post_rst_len", cmd_length, 3);
    read_check("post_rst_rd2", 4'd2, 8'h03);
    check("post_rst_cnt", error_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
